// File: rtl/alarma_ring_ctrl.sv
// Alarm ring session controller: turns the comparator match level into a timed
// buzzer session with user stop, limited snooze and automatic timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an enabled rising edge of activring
// RINGING  | buzzer pattern active, counting seconds towards timeout
// SNOOZE   | buzzer silent, counting seconds until the ring resumes
// WAIT_CLR | session over, waiting for activring to drop before re-arming
module alarma_ring_ctrl #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 255,
    parameter int MAX_SNOOZE     = 3,
    parameter int PATTERN_DIV    = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarma_on,
    input  logic       activring,
    input  logic       tick_1hz,
    input  logic       btn_apagar,
    input  logic       btn_snooze,
    output logic       ring_out,
    output logic       led_ring,
    output logic       ringing,
    output logic [3:0] snooze_left
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZE   = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [7:0]  SNOOZE_LAST = 8'(SNOOZE_S - 1);
    localparam logic [24:0] PAT_LAST    = 25'(PATTERN_DIV - 1);
    localparam logic [3:0]  SNOOZE_INIT = 4'(MAX_SNOOZE);

    state_t      state;
    logic        armed;
    logic        act_q;
    logic        apg_q;
    logic        snz_q;
    logic [7:0]  sec_cnt;
    logic [24:0] pat_cnt;

    logic act_rise;
    logic apg_rise;
    logic snz_rise;

    assign act_rise = activring  & ~act_q;
    assign apg_rise = btn_apagar & ~apg_q;
    assign snz_rise = btn_snooze & ~snz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            act_q       <= 1'b0;
            apg_q       <= 1'b0;
            snz_q       <= 1'b0;
            sec_cnt     <= 8'd0;
            pat_cnt     <= 25'd0;
            ring_out    <= 1'b0;
            led_ring    <= 1'b0;
            ringing     <= 1'b0;
            snooze_left <= SNOOZE_INIT;
        end else begin
            act_q <= activring;
            apg_q <= btn_apagar;
            snz_q <= btn_snooze;

            // First cycle after reset only captures the input levels, so a
            // match still high across reset is not seen as a new edge.
            if (!armed) begin
                armed <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (act_rise && alarma_on) begin
                            state       <= RINGING;
                            sec_cnt     <= 8'd0;
                            pat_cnt     <= 25'd0;
                            snooze_left <= SNOOZE_INIT;
                            ring_out    <= 1'b1;
                            led_ring    <= 1'b1;
                            ringing     <= 1'b1;
                        end
                    end

                    RINGING: begin
                        if (!alarma_on) begin
                            state    <= IDLE;
                            ring_out <= 1'b0;
                            led_ring <= 1'b0;
                            ringing  <= 1'b0;
                        end else if (apg_rise) begin
                            state    <= WAIT_CLR;
                            ring_out <= 1'b0;
                            led_ring <= 1'b0;
                            ringing  <= 1'b0;
                        end else if (snz_rise) begin
                            ring_out <= 1'b0;
                            ringing  <= 1'b0;
                            if (snooze_left != 4'd0) begin
                                state       <= SNOOZE;
                                snooze_left <= snooze_left - 4'd1;
                                sec_cnt     <= 8'd0;
                            end else begin
                                state    <= WAIT_CLR;
                                led_ring <= 1'b0;
                            end
                        end else if (tick_1hz && sec_cnt == RING_LAST) begin
                            state    <= WAIT_CLR;
                            ring_out <= 1'b0;
                            led_ring <= 1'b0;
                            ringing  <= 1'b0;
                        end else begin
                            if (tick_1hz) begin
                                sec_cnt <= sec_cnt + 8'd1;
                            end
                            if (pat_cnt == PAT_LAST) begin
                                pat_cnt  <= 25'd0;
                                ring_out <= ~ring_out;
                            end else begin
                                pat_cnt <= pat_cnt + 25'd1;
                            end
                        end
                    end

                    SNOOZE: begin
                        if (!alarma_on) begin
                            state    <= IDLE;
                            led_ring <= 1'b0;
                        end else if (apg_rise) begin
                            state    <= WAIT_CLR;
                            led_ring <= 1'b0;
                        end else if (tick_1hz && sec_cnt == SNOOZE_LAST) begin
                            state    <= RINGING;
                            sec_cnt  <= 8'd0;
                            pat_cnt  <= 25'd0;
                            ring_out <= 1'b1;
                            ringing  <= 1'b1;
                        end else if (tick_1hz) begin
                            sec_cnt <= sec_cnt + 8'd1;
                        end
                    end

                    WAIT_CLR: begin
                        if (!activring) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        ring_out <= 1'b0;
                        led_ring <= 1'b0;
                        ringing  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/alarma_ring_ctrl.md
Name: alarma_ring_ctrl

Overview:
- Downstream consumer of the alarm-match indicator `activring`.
- Turns the match level into a timed ring session with a buzzer on/off pattern, an LED indicator, user stop ("apagar"), limited snooze and an automatic timeout.
- Sits between the alarm comparator and the board buzzer/LED pins.
- Second timing comes from the design's shared 1 Hz tick.

Parameters:
RING_TIMEOUT_S, 60, seconds (tick_1hz pulses) a ring session lasts before auto-stop; legal 1..255
SNOOZE_S, 255, seconds of silence per snooze; legal 1..255
MAX_SNOOZE, 3, snoozes allowed per alarm event; legal 0..15
PATTERN_DIV, 25000000, clk cycles per buzzer half-period; legal >=1, counter width 25 bits

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
alarma_on  input  1  alarm enable level from the configuration logic
activring  input  1  level from the alarm comparator; 1 while the RTC time equals the alarm time
tick_1hz  input  1  one-clk-wide pulse, once per second
btn_apagar  input  1  debounced stop button, level; rising edge is used
btn_snooze  input  1  debounced snooze button, level; rising edge is used
ring_out  output  1  buzzer drive: pattern while ringing, else 0
led_ring  output  1  1 in RINGING or SNOOZE
ringing  output  1  1 only in RINGING
snooze_left  output  4  remaining snoozes for the current event

Behaviour:
- Async reset:
  - State = IDLE.
  - All counters and edge registers = 0.
  - ring_out = 0, led_ring = 0, ringing = 0.
  - snooze_left = MAX_SNOOZE.
- Edge detect: registered copies act_q, apg_q, snz_q.
  - act_rise = activring & ~act_q; likewise apg_rise and snz_rise.
- States:
  - IDLE: act_rise & alarma_on -> RINGING; clear sec_cnt and pat_cnt; snooze_left = MAX_SNOOZE.
  - RINGING: events in priority order:
    1. alarma_on=0 -> IDLE
    2. apg_rise -> WAIT_CLR
    3. snz_rise with snooze_left>0 -> SNOOZE; snooze_left-1; clear sec_cnt
    4. snz_rise with snooze_left=0 -> WAIT_CLR (treated as stop)
    5. tick_1hz with sec_cnt==RING_TIMEOUT_S-1 -> WAIT_CLR
    6. otherwise sec_cnt += tick_1hz
  - SNOOZE:
    - alarma_on=0 -> IDLE.
    - apg_rise -> WAIT_CLR.
    - tick_1hz with sec_cnt==SNOOZE_S-1 -> RINGING; clear sec_cnt and pat_cnt.
    - Else sec_cnt += tick_1hz.
    - snz_rise is ignored.
  - WAIT_CLR: activring==0 -> IDLE. This blocks a re-trigger within the same matching second.
- Outputs are Moore-decoded from registered state, so they change on the same edge as the state. Latency from a sampled event to output change is 1 clk.
- Pattern (RINGING only):
  - pat_cnt counts 0..PATTERN_DIV-1 and wraps.
  - ring_out toggles on each wrap.
  - ring_out = 1 on the first RINGING cycle.
  - ring_out is forced 0 in every other state.
- Simultaneous events: the priority list above applies. A tick on the same cycle as apg_rise or snz_rise does not advance sec_cnt.
- Counter widths:
  - sec_cnt is 8 bits and cannot overflow given the parameter ranges.
  - snooze_left saturates at 0.
- activring falling while RINGING or SNOOZE does not end the session.
- Reset mid-session returns to IDLE immediately. A still-high activring after reset does not ring, because act_q resets to 0 and the first cycle creates a rise. To avoid this, act_q loads activring during the first post-reset cycle with no transition allowed that cycle.

Test Plan:
- Params RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZE=2, PATTERN_DIV=4. Raise activring with alarma_on=1 -> ringing=1 next clk; ring_out = 1,1,1,1,0,0,0,0,... ; after 5 tick_1hz pulses -> ringing=0, WAIT_CLR until activring=0, then IDLE.
- While ringing, btn_apagar rises -> next clk ring_out=0, led_ring=0. Holding activring=1 produces no re-ring; drop and re-raise activring -> ring resumes.
- Snooze twice: first snz_rise -> snooze_left=1, led_ring=1, ring_out=0; after 3 ticks RINGING again with pattern restarted at 1. Second snz_rise -> snooze_left=0. Third snz_rise -> WAIT_CLR.
- Same clk: tick_1hz and btn_snooze rise with sec_cnt=4 -> SNOOZE is entered (not timeout), sec_cnt=0.
- alarma_on dropped during SNOOZE -> IDLE next clk, all outputs 0, snooze_left restored to 2 on the next trigger.
- Assert reset mid-RINGING with activring=1 -> outputs 0 asynchronously; after release no ring until activring falls and rises again.
